irrigation_countdown: RTL



---
 rtl/irrigation_countdown.sv | 138 +++++++++++++
 1 files changed

// File: rtl/irrigation_countdown.sv
// BCD MM:S0 irrigation countdown: registered outputs, 1-cycle load/decrement latency, no backpressure.
// Optional seconds-units digit (1 Hz tick) enabled by `define COUNTDOWN_SECONDS_U_EN; default uses 0.1 Hz tick.
module irrigation_countdown (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_req_i,
  input  logic [1:0] minutes_d_preset_i,
  input  logic [3:0] minutes_u_preset_i,
  input  logic [2:0] seconds_d_preset_i,
  input  logic       tick_i,
  input  logic       irrigation_on_i,
  output logic [1:0] minutes_d_o,
  output logic [3:0] minutes_u_o,
  output logic [2:0] seconds_d_o,
`ifdef COUNTDOWN_SECONDS_U_EN
  output logic [3:0] seconds_u_o,
`endif
  output logic       running_o,
  output logic       expired_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] md_q, md_d;
  logic [3:0] mu_q, mu_d;
  logic [2:0] sd_q, sd_d;
  logic       running_q, running_d;
  logic       expired_q, expired_d;
  logic       borrow;
  logic [3:0] mu_clamp;
  logic [2:0] sd_clamp;
`ifdef COUNTDOWN_SECONDS_U_EN
  logic [3:0] su_q, su_d;
`endif

  assign mu_clamp = (minutes_u_preset_i > 4'd9) ? 4'd9 : minutes_u_preset_i;
  assign sd_clamp = (seconds_d_preset_i > 3'd5) ? 3'd5 : seconds_d_preset_i;

  always_comb begin
    state_d   = state_q;
    md_d      = md_q;
    mu_d      = mu_q;
    sd_d      = sd_q;
    expired_d = 1'b0;
    borrow    = 1'b1;
`ifdef COUNTDOWN_SECONDS_U_EN
    su_d      = su_q;
`endif

    if (load_req_i) begin
      // A same-cycle tick is dropped: load wins outright.
      md_d = minutes_d_preset_i;
      mu_d = mu_clamp;
      sd_d = sd_clamp;
`ifdef COUNTDOWN_SECONDS_U_EN
      su_d = 4'd0;
`endif
      if ({minutes_d_preset_i, mu_clamp, sd_clamp} == 9'd0) state_d = IDLE;
      else if (irrigation_on_i)                               state_d = RUNNING;
      else                                                    state_d = PAUSED;
    end else begin
      case (state_q)
        RUNNING: begin
          if (!irrigation_on_i) begin
            state_d = PAUSED;
          end else if (tick_i) begin
`ifdef COUNTDOWN_SECONDS_U_EN
            if (su_q == 4'd0) su_d = 4'd9;
            else begin su_d = su_q - 4'd1; borrow = 1'b0; end
`endif
            if (borrow) begin
              if (sd_q == 3'd0) sd_d = 3'd5;
              else begin sd_d = sd_q - 3'd1; borrow = 1'b0; end
            end
            if (borrow) begin
              if (mu_q == 4'd0) mu_d = 4'd9;
              else begin mu_d = mu_q - 4'd1; borrow = 1'b0; end
            end
            if (borrow) md_d = md_q - 2'd1;
            // RUNNING is only entered with a non-zero count, so this never wraps.
`ifdef COUNTDOWN_SECONDS_U_EN
            if ({md_d, mu_d, sd_d, su_d} == 13'd0) begin
`else
            if ({md_d, mu_d, sd_d} == 9'd0) begin
`endif
              state_d   = EXPIRED;
              expired_d = 1'b1;
            end
          end
        end
        PAUSED:  if (irrigation_on_i) state_d = RUNNING;
        default: state_d = state_q;
      endcase
    end

    running_d = (state_d == RUNNING);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      md_q      <= 2'd0;
      mu_q      <= 4'd0;
      sd_q      <= 3'd0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
`ifdef COUNTDOWN_SECONDS_U_EN
      su_q      <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      md_q      <= md_d;
      mu_q      <= mu_d;
      sd_q      <= sd_d;
      running_q <= running_d;
      expired_q <= expired_d;
`ifdef COUNTDOWN_SECONDS_U_EN
      su_q      <= su_d;
`endif
    end
  end

  assign minutes_d_o = md_q;
  assign minutes_u_o = mu_q;
  assign seconds_d_o = sd_q;
`ifdef COUNTDOWN_SECONDS_U_EN
  assign seconds_u_o = su_q;
`endif
  assign running_o   = running_q;
  assign expired_o   = expired_q;

endmodule
